logic_axi4_lite_serializer: RTL and testbench

Upstream companion of the AXI4-Lite to Avalon-MM bridge. It takes an unconstrained AXI4-Lite slave port and re-issues traffic on an AXI4-Lite master port with exactly one transaction in flight. Each write presents AW and W together in the same cycles, and a read is never issued while a write is pending, so the bridge's shared Avalon address/byteenable path never sees overlapping read/write. AW, W and AR are each absorbed by single-entry holding slots; reads and writes are arbitrated round-robin.

---
 rtl/logic_axi4_lite_pkg.sv | 9 +
 rtl/logic_axi4_lite_if.sv | 36 +++
 rtl/logic_axi4_lite_serializer_slot.sv | 30 +++
 rtl/logic_axi4_lite_serializer.sv | 114 +++++++++++
 tb/tb_logic_axi4_lite_serializer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_axi4_lite_pkg.sv
// logic_axi4_lite_pkg: shared AXI4-Lite types for the serializer and bridge
package logic_axi4_lite_pkg;
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } response_t;
endpackage

// File: rtl/logic_axi4_lite_if.sv
// logic_axi4_lite_if: AXI4-Lite bundle with slave/master views
interface logic_axi4_lite_if
    import logic_axi4_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    response_t           bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    response_t           rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/logic_axi4_lite_serializer_slot.sv
// logic_axi4_lite_serializer_slot: single-entry holding slot, cleared on transaction completion
module logic_axi4_lite_serializer_slot #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_full,
    output logic [WIDTH-1:0] out_data,
    input  logic             clear
);
    logic             full_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready = !full_q;
    assign out_full = full_q;
    assign out_data = data_q;

    always_ff @(posedge aclk) begin
        if (areset) full_q <= 1'b0;
        else if (clear) full_q <= 1'b0;
        else if (in_valid && !full_q) full_q <= 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (in_valid && !full_q) data_q <= in_data;
    end
endmodule

// File: rtl/logic_axi4_lite_serializer.sv
// logic_axi4_lite_serializer: re-issues AXI4-Lite traffic with exactly one transaction in flight
module logic_axi4_lite_serializer
    import logic_axi4_lite_pkg::*;
#(
    parameter bit WRITE_PRIORITY = 1'b0
) (
    input  logic              aclk,
    input  logic              areset,
    logic_axi4_lite_if.slave  slave,
    logic_axi4_lite_if.master master
);
    localparam int AW = $bits(slave.awaddr);
    localparam int DW = $bits(slave.wdata);
    localparam int SW = $bits(slave.wstrb);

    typedef enum logic [2:0] {IDLE, WRITE_ISSUE, WRITE_RESP, READ_ISSUE, READ_RESP} state_e;
    typedef enum logic {GRANT_READ, GRANT_WRITE} grant_e;

    state_e  state_q;
    grant_e  last_grant_q;
    logic    aw_done_q, w_done_q, awvalid_q, wvalid_q, arvalid_q;
    logic    aw_full, w_full, ar_full;
    logic [AW+2:0]   aw_data, ar_data;
    logic [DW+SW-1:0] w_data;

    wire aw_hs = awvalid_q && master.awready;
    wire w_hs  = wvalid_q && master.wready;
    wire ar_hs = arvalid_q && master.arready;
    wire b_hs  = (state_q == WRITE_RESP) && master.bvalid && slave.bready;
    wire r_hs  = (state_q == READ_RESP) && master.rvalid && slave.rready;
    wire write_pending = aw_full && w_full;
    wire read_pending  = ar_full;

    logic_axi4_lite_serializer_slot #(.WIDTH(AW+3)) u_aw_slot (
        .aclk, .areset, .in_valid(slave.awvalid), .in_ready(slave.awready),
        .in_data({slave.awprot, slave.awaddr}), .out_full(aw_full), .out_data(aw_data), .clear(b_hs)
    );
    logic_axi4_lite_serializer_slot #(.WIDTH(DW+SW)) u_w_slot (
        .aclk, .areset, .in_valid(slave.wvalid), .in_ready(slave.wready),
        .in_data({slave.wstrb, slave.wdata}), .out_full(w_full), .out_data(w_data), .clear(b_hs)
    );
    logic_axi4_lite_serializer_slot #(.WIDTH(AW+3)) u_ar_slot (
        .aclk, .areset, .in_valid(slave.arvalid), .in_ready(slave.arready),
        .in_data({slave.arprot, slave.araddr}), .out_full(ar_full), .out_data(ar_data), .clear(r_hs)
    );

    assign master.awaddr  = aw_data[AW-1:0];
    assign master.awprot  = aw_data[AW+:3];
    assign master.awvalid = awvalid_q;
    assign master.wdata   = w_data[DW-1:0];
    assign master.wstrb   = w_data[DW+:SW];
    assign master.wvalid  = wvalid_q;
    assign master.araddr  = ar_data[AW-1:0];
    assign master.arprot  = ar_data[AW+:3];
    assign master.arvalid = arvalid_q;
    // Responses pass straight through, but only while the matching RESP state owns the channel
    assign master.bready  = (state_q == WRITE_RESP) && slave.bready;
    assign slave.bvalid   = (state_q == WRITE_RESP) && master.bvalid;
    assign slave.bresp    = master.bresp;
    assign master.rready  = (state_q == READ_RESP) && slave.rready;
    assign slave.rvalid   = (state_q == READ_RESP) && master.rvalid;
    assign slave.rdata    = master.rdata;
    assign slave.rresp    = master.rresp;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_READ;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // last_grant only moves on contention so alternation is between competing requests
                    if (write_pending && (!read_pending || WRITE_PRIORITY || last_grant_q == GRANT_READ)) begin
                        state_q   <= WRITE_ISSUE;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (read_pending) last_grant_q <= GRANT_WRITE;
                    end else if (read_pending) begin
                        state_q   <= READ_ISSUE;
                        arvalid_q <= 1'b1;
                        if (write_pending) last_grant_q <= GRANT_READ;
                    end
                end
                WRITE_ISSUE: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_q <= WRITE_RESP;
                end
                WRITE_RESP: if (b_hs) state_q <= IDLE;
                READ_ISSUE: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        state_q   <= READ_RESP;
                    end
                end
                READ_RESP: if (r_hs) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_axi4_lite_serializer.sv
// tb_logic_axi4_lite_serializer: scoreboard bench for the one-in-flight AXI4-Lite serializer
module tb_logic_axi4_lite_serializer;
    import logic_axi4_lite_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;
    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    txn_t exp_q[$];
    rsp_t rsp_q[$];
    txn_t t;
    rsp_t r;

    logic_axi4_lite_if s_if ();
    logic_axi4_lite_if m_if ();

    logic_axi4_lite_serializer #(.WRITE_PRIORITY(1'b0)) dut (
        .aclk(clk),
        .areset(rst),
        .slave(s_if),
        .master(m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_up();
        s_if.awvalid = 1'b0;
        s_if.wvalid  = 1'b0;
        s_if.arvalid = 1'b0;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit do_aw, input bit do_w);
        s_if.awvalid = do_aw;
        s_if.awaddr  = a;
        s_if.awprot  = 3'd0;
        s_if.wvalid  = do_w;
        s_if.wdata   = d;
        s_if.wstrb   = s;
    endtask

    task automatic drive_read(input logic [31:0] a);
        s_if.arvalid = 1'b1;
        s_if.araddr  = a;
        s_if.arprot  = 3'd0;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_q.push_back('{1'b1, a, d, s});
    endtask

    task automatic push_rd(input logic [31:0] a);
        exp_q.push_back('{1'b0, a, 32'h0, 4'h0});
    endtask

    task automatic drive_b(input response_t resp);
        m_if.bvalid = 1'b1;
        m_if.bresp  = resp;
        rsp_q.push_back('{resp, 32'h0});
        #1;
    endtask

    task automatic drive_r(input response_t resp, input logic [31:0] d);
        m_if.rvalid = 1'b1;
        m_if.rresp  = resp;
        m_if.rdata  = d;
        rsp_q.push_back('{resp, d});
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid, s_if.awready, s_if.wready, s_if.arready} !== 8'b00000111) begin
            n_err++;
            $display("FAIL reset_during: got %b required 00000111", {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid, s_if.awready, s_if.wready, s_if.arready});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid, s_if.awready, s_if.wready, s_if.arready} !== 8'b00000111) begin
            n_err++;
            $display("FAIL reset_after: got %b required 00000111", {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid, s_if.awready, s_if.wready, s_if.arready});
        end
    endtask

    task automatic test_single_write();
        drive_write(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
        push_wr(32'h10, 32'hDEADBEEF, 4'hF);
        tick();
        idle_up();
        n_cmp++;
        if ({m_if.awvalid, m_if.wvalid, s_if.awready, s_if.wready} !== 4'b0000) begin
            n_err++;
            $display("FAIL single_n1: got %b required 0000", {m_if.awvalid, m_if.wvalid, s_if.awready, s_if.wready});
        end
        tick();
        t = exp_q.pop_front();
        n_cmp++;
        if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.awaddr, m_if.wdata, m_if.wstrb} !== {t.wr, t.wr, 1'b0, t.addr, t.data, t.strb}) begin
            n_err++;
            $display("FAIL single_issue: got addr %h data %h strb %h required addr %h data %h strb %h", m_if.awaddr, m_if.wdata, m_if.wstrb, t.addr, t.data, t.strb);
        end
        tick();
        n_cmp++;
        if ({m_if.awvalid, m_if.wvalid, s_if.bvalid, m_if.bready} !== 4'b0001) begin
            n_err++;
            $display("FAIL single_resp_wait: got %b required 0001", {m_if.awvalid, m_if.wvalid, s_if.bvalid, m_if.bready});
        end
        drive_b(OKAY);
        r = rsp_q.pop_front();
        n_cmp++;
        if ({s_if.bvalid, s_if.bresp} !== {1'b1, r.resp}) begin
            n_err++;
            $display("FAIL single_b: got %b required %b", {s_if.bvalid, s_if.bresp}, {1'b1, r.resp});
        end
        tick();
        m_if.bvalid = 1'b0;
        #1;
        n_cmp++;
        if ({s_if.bvalid, s_if.awready, s_if.wready} !== 3'b011) begin
            n_err++;
            $display("FAIL single_done: got %b required 011", {s_if.bvalid, s_if.awready, s_if.wready});
        end
    endtask

    task automatic test_w_before_aw();
        drive_write(32'h20, 32'hCAFEF00D, 4'h3, 1'b0, 1'b1);
        push_wr(32'h20, 32'hCAFEF00D, 4'h3);
        tick();
        idle_up();
        n_cmp++;
        if ({s_if.wready, s_if.awready} !== 2'b01) begin
            n_err++;
            $display("FAIL wfirst_buffered: got %b required 01", {s_if.wready, s_if.awready});
        end
        tick();
        drive_write(32'h20, 32'hCAFEF00D, 4'h3, 1'b1, 1'b0);
        tick();
        idle_up();
        n_cmp++;
        if ({m_if.awvalid, m_if.wvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL wfirst_early: got %b required 00", {m_if.awvalid, m_if.wvalid});
        end
        tick();
        t = exp_q.pop_front();
        n_cmp++;
        if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.awaddr, m_if.wdata, m_if.wstrb} !== {t.wr, t.wr, 1'b0, t.addr, t.data, t.strb}) begin
            n_err++;
            $display("FAIL wfirst_issue: got addr %h data %h strb %h required addr %h data %h strb %h", m_if.awaddr, m_if.wdata, m_if.wstrb, t.addr, t.data, t.strb);
        end
        tick();
        n_cmp++;
        if (s_if.wready !== 1'b0) begin
            n_err++;
            $display("FAIL wfirst_wready_resp: got %b required 0", s_if.wready);
        end
        drive_b(OKAY);
        r = rsp_q.pop_front();
        n_cmp++;
        if ({s_if.bvalid, s_if.bresp} !== {1'b1, r.resp}) begin
            n_err++;
            $display("FAIL wfirst_b: got %b required %b", {s_if.bvalid, s_if.bresp}, {1'b1, r.resp});
        end
        tick();
        m_if.bvalid = 1'b0;
        n_cmp++;
        if ({s_if.wready, s_if.awready} !== 2'b11) begin
            n_err++;
            $display("FAIL wfirst_release: got %b required 11", {s_if.wready, s_if.awready});
        end
    endtask

    task automatic test_arbitration();
        for (int p = 0; p < 2; p++) begin
            drive_write(32'h40 + 32'(p * 4), 32'h11112222 + 32'(p), 4'hF, 1'b1, 1'b1);
            drive_read(32'h30 + 32'(p * 4));
            if (p == 0) begin
                push_wr(32'h40, 32'h11112222, 4'hF);
                push_rd(32'h30);
            end else begin
                push_rd(32'h34);
                push_wr(32'h44, 32'h11112223, 4'hF);
            end
            tick();
            idle_up();
            tick();
            for (int k = 0; k < 2; k++) begin
                t = exp_q.pop_front();
                if (t.wr) begin
                    n_cmp++;
                    if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.awaddr, m_if.wdata, m_if.wstrb} !== {2'b11, 1'b0, t.addr, t.data, t.strb}) begin
                        n_err++;
                        $display("FAIL arb%0d_%0d_write: got v %b addr %h required v 110 addr %h", p, k, {m_if.awvalid, m_if.wvalid, m_if.arvalid}, m_if.awaddr, t.addr);
                    end
                    tick();
                    drive_b(OKAY);
                    r = rsp_q.pop_front();
                    n_cmp++;
                    if ({s_if.bvalid, s_if.bresp, m_if.arvalid} !== {1'b1, r.resp, 1'b0}) begin
                        n_err++;
                        $display("FAIL arb%0d_%0d_b: got %b required %b", p, k, {s_if.bvalid, s_if.bresp, m_if.arvalid}, {1'b1, r.resp, 1'b0});
                    end
                    tick();
                    m_if.bvalid = 1'b0;
                end else begin
                    n_cmp++;
                    if ({m_if.arvalid, m_if.araddr, m_if.awvalid} !== {1'b1, t.addr, 1'b0}) begin
                        n_err++;
                        $display("FAIL arb%0d_%0d_read: got ar %b addr %h aw %b required ar 1 addr %h aw 0", p, k, m_if.arvalid, m_if.araddr, m_if.awvalid, t.addr);
                    end
                    tick();
                    drive_r(OKAY, 32'hA5A50000 | t.addr);
                    r = rsp_q.pop_front();
                    n_cmp++;
                    if ({s_if.rvalid, s_if.rdata, s_if.rresp} !== {1'b1, r.data, r.resp}) begin
                        n_err++;
                        $display("FAIL arb%0d_%0d_r: got %b %h required 1 %h", p, k, s_if.rvalid, s_if.rdata, r.data);
                    end
                    tick();
                    m_if.rvalid = 1'b0;
                end
                tick();
            end
        end
    endtask

    task automatic test_aw_stall();
        m_if.awready = 1'b0;
        drive_write(32'h60, 32'h60606060, 4'hC, 1'b1, 1'b1);
        push_wr(32'h60, 32'h60606060, 4'hC);
        tick();
        idle_up();
        tick();
        t = exp_q.pop_front();
        n_cmp++;
        if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.awaddr, m_if.wdata, m_if.wstrb} !== {2'b11, 1'b0, t.addr, t.data, t.strb}) begin
            n_err++;
            $display("FAIL stall_issue: got addr %h data %h required addr %h data %h", m_if.awaddr, m_if.wdata, t.addr, t.data);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({m_if.awvalid, m_if.wvalid, m_if.awaddr} !== {2'b10, t.addr}) begin
                n_err++;
                $display("FAIL stall_hold%0d: got %b addr %h required 10 addr %h", k, {m_if.awvalid, m_if.wvalid}, m_if.awaddr, t.addr);
            end
        end
        m_if.awready = 1'b1;
        tick();
        n_cmp++;
        if ({m_if.awvalid, m_if.wvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL stall_drop: got %b required 00", {m_if.awvalid, m_if.wvalid});
        end
        drive_b(OKAY);
        r = rsp_q.pop_front();
        n_cmp++;
        if ({s_if.bvalid, s_if.bresp} !== {1'b1, r.resp}) begin
            n_err++;
            $display("FAIL stall_b: got %b required %b", {s_if.bvalid, s_if.bresp}, {1'b1, r.resp});
        end
        tick();
        m_if.bvalid = 1'b0;
        #1;
        n_cmp++;
        if (s_if.bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_single_b: got %b required 0", s_if.bvalid);
        end
        m_if.bvalid = 1'b1;
        #1;
        n_cmp++;
        if ({s_if.bvalid, m_if.bready} !== 2'b00) begin
            n_err++;
            $display("FAIL stray_b: got %b required 00", {s_if.bvalid, m_if.bready});
        end
        m_if.bvalid = 1'b0;
        tick();
    endtask

    task automatic test_rready_hold();
        drive_read(32'h70);
        push_rd(32'h70);
        tick();
        idle_up();
        tick();
        t = exp_q.pop_front();
        n_cmp++;
        if ({m_if.arvalid, m_if.araddr} !== {~t.wr, t.addr}) begin
            n_err++;
            $display("FAIL hold_ar: got %b addr %h required 1 addr %h", m_if.arvalid, m_if.araddr, t.addr);
        end
        tick();
        s_if.rready = 1'b0;
        drive_r(OKAY, 32'h1234);
        r = rsp_q.pop_front();
        drive_write(32'h80, 32'h80808080, 4'hF, 1'b1, 1'b1);
        push_wr(32'h80, 32'h80808080, 4'hF);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({s_if.rvalid, s_if.rdata, s_if.rresp, m_if.rready, m_if.awvalid, m_if.arvalid} !== {1'b1, r.data, r.resp, 3'b000}) begin
                n_err++;
                $display("FAIL hold_r%0d: got v %b data %h rr %b aw %b ar %b required v 1 data %h rr 0 aw 0 ar 0", k, s_if.rvalid, s_if.rdata, m_if.rready, m_if.awvalid, m_if.arvalid, r.data);
            end
            tick();
            idle_up();
        end
        s_if.rready = 1'b1;
        #1;
        n_cmp++;
        if ({s_if.rvalid, m_if.rready} !== 2'b11) begin
            n_err++;
            $display("FAIL hold_release: got %b required 11", {s_if.rvalid, m_if.rready});
        end
        tick();
        m_if.rvalid = 1'b0;
        tick();
        t = exp_q.pop_front();
        n_cmp++;
        if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.awaddr, m_if.wdata, m_if.wstrb} !== {t.wr, t.wr, 1'b0, t.addr, t.data, t.strb}) begin
            n_err++;
            $display("FAIL hold_next_write: got addr %h data %h required addr %h data %h", m_if.awaddr, m_if.wdata, t.addr, t.data);
        end
        tick();
        drive_b(OKAY);
        r = rsp_q.pop_front();
        tick();
        m_if.bvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive_write(32'h90, 32'h90909090, 4'hF, 1'b1, 1'b1);
        push_wr(32'h90, 32'h90909090, 4'hF);
        tick();
        idle_up();
        tick();
        t = exp_q.pop_front();
        tick();
        s_if.bready = 1'b0;
        drive_b(SLVERR);
        r = rsp_q.pop_front();
        n_cmp++;
        if ({s_if.bvalid, s_if.bresp, m_if.bready} !== {1'b1, r.resp, 1'b0}) begin
            n_err++;
            $display("FAIL rstmid_b: got %b required %b", {s_if.bvalid, s_if.bresp, m_if.bready}, {1'b1, r.resp, 1'b0});
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid, m_if.bready, s_if.awready, s_if.wready, s_if.arready} !== 9'b000000111) begin
            n_err++;
            $display("FAIL rstmid_clear: got %b required 000000111", {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid, m_if.bready, s_if.awready, s_if.wready, s_if.arready});
        end
        m_if.bvalid = 1'b0;
        s_if.bready = 1'b1;
        drive_read(32'h50);
        push_rd(32'h50);
        tick();
        idle_up();
        tick();
        t = exp_q.pop_front();
        n_cmp++;
        if ({m_if.arvalid, m_if.araddr, m_if.awvalid} !== {~t.wr, t.addr, 1'b0}) begin
            n_err++;
            $display("FAIL rstmid_ar: got %b addr %h required 1 addr %h", m_if.arvalid, m_if.araddr, t.addr);
        end
        tick();
        drive_r(OKAY, 32'h5050);
        r = rsp_q.pop_front();
        n_cmp++;
        if ({s_if.rvalid, s_if.rdata, s_if.rresp} !== {1'b1, r.data, r.resp}) begin
            n_err++;
            $display("FAIL rstmid_r: got %b %h required 1 %h", s_if.rvalid, s_if.rdata, r.data);
        end
        tick();
        m_if.rvalid = 1'b0;
        #1;
        n_cmp++;
        if ({s_if.rvalid, s_if.arready} !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_done: got %b required 01", {s_if.rvalid, s_if.arready});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        s_if.awvalid = 1'b0; s_if.awaddr = '0; s_if.awprot = '0;
        s_if.wvalid = 1'b0;  s_if.wdata = '0;  s_if.wstrb = '0;
        s_if.arvalid = 1'b0; s_if.araddr = '0; s_if.arprot = '0;
        s_if.bready = 1'b1;  s_if.rready = 1'b1;
        m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
        m_if.bvalid = 1'b0;  m_if.bresp = OKAY;
        m_if.rvalid = 1'b0;  m_if.rresp = OKAY; m_if.rdata = '0;
        test_reset();
        test_single_write();
        test_w_before_aw();
        test_arbitration();
        test_aw_stall();
        test_rready_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
